divu_iter: RTL

Iterative 32-bit unsigned divider that runs a restoring shift-subtract loop. Each trial subtraction is one pass through the team's 32-bit carry-lookahead adder (`cla`), computed as remainder + ~divisor + 1. The block sits directly upstream of `cla`: it registers operands, drives the adder's operands every iteration, and consumes the adder's sum. It exposes valid/ready handshakes toward the execute stage.

---
 rtl/divu_pkg.sv | 20 ++
 rtl/cla.sv | 41 ++++
 rtl/divu_step.sv | 39 +++
 rtl/divu_iter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared definitions for the iterative unsigned divider: datapath width,
// FSM state type and iteration-counter sizing.
package divu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divu_state_t;

  // Counter only has to reach N-1, where N = WIDTH / iterations per cycle.
  function automatic int divu_cnt_w(input int iters_per_cycle);
    int n;
    n = WIDTH / iters_per_cycle;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
// Group carries ripple from one group to the next. Carry-out is not exported.
module cla #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  localparam int NG = W / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = cin_i;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    // The top group's carry-out is never consumed, so it is not built.
    if (k < NG - 1) begin : g_cout
      logic gg;
      logic pg;
      assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign pg = &p[B+3:B];
      assign c[B+4] = gg | (pg & c[B]);
    end
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/divu_step.sv
// One combinational restoring shift-subtract step. The trial subtraction is
// a single pass through cla as rem + ~divisor + 1.
module divu_step
  import divu_pkg::*;
(
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             c31;
  logic             cout;
  logic             ge;

  assign a = {rem_in[WIDTH-2:0], q_in[WIDTH-1]};
  assign b = ~divisor;

  cla #(.W(WIDTH)) u_cla (
    .a_i   (a),
    .b_i   (b),
    .cin_i (1'b1),
    .sum_o (sum)
  );

  // Recover the adder's carry-out from its MSB. The shifted-out remainder
  // bit makes the 33-bit partial remainder exceed any 32-bit divisor.
  assign c31  = sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
  assign cout = (a[WIDTH-1] & b[WIDTH-1]) | (a[WIDTH-1] & c31) | (b[WIDTH-1] & c31);
  assign ge   = rem_in[WIDTH-1] | cout;

  assign rem_out = ge ? sum : a;
  assign q_out   = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/divu_iter.sv
// Iterative 32-bit unsigned restoring divider with valid/ready handshakes.
// Optional macro DIVU_EARLY_OUT_EN adds a one-cycle path for x/0 and dividend < divisor.
module divu_iter
  import divu_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int                N     = WIDTH / ITERS_PER_CYCLE;
  localparam int                CNT_W = divu_cnt_w(ITERS_PER_CYCLE);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

  divu_state_t      state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] divisor_q;
  logic             ready_q;
  logic             valid_q;

  logic [WIDTH-1:0] remChain  [ITERS_PER_CYCLE+1];
  logic [WIDTH-1:0] quotChain [ITERS_PER_CYCLE+1];
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  logic             accept;
  logic             earlyOut;
  logic [WIDTH-1:0] earlyQuot;

  assign remChain[0]  = rem_q;
  assign quotChain[0] = quot_q;

  for (genvar k = 0; k < ITERS_PER_CYCLE; k++) begin : g_step
    divu_step u_step (
      .rem_in  (remChain[k]),
      .q_in    (quotChain[k]),
      .divisor (divisor_q),
      .rem_out (remChain[k+1]),
      .q_out   (quotChain[k+1])
    );
  end

  assign rem_d  = remChain[ITERS_PER_CYCLE];
  assign quot_d = quotChain[ITERS_PER_CYCLE];
  assign accept = i_valid & ready_q;

`ifdef DIVU_EARLY_OUT_EN
  logic [WIDTH-1:0] cmpB;
  logic [WIDTH-1:0] cmpSum;
  logic             cmpC31;
  logic             dividendGe;
  logic             divZero;

  assign cmpB = ~i_divisor;

  cla #(.W(WIDTH)) u_cmp (
    .a_i   (i_dividend),
    .b_i   (cmpB),
    .cin_i (1'b1),
    .sum_o (cmpSum)
  );

  assign cmpC31     = cmpSum[WIDTH-1] ^ i_dividend[WIDTH-1] ^ cmpB[WIDTH-1];
  assign dividendGe = (i_dividend[WIDTH-1] & cmpB[WIDTH-1]) | (i_dividend[WIDTH-1] & cmpC31)
                    | (cmpB[WIDTH-1] & cmpC31);
  assign divZero    = (i_divisor == '0);
  assign earlyOut   = divZero | ~dividendGe;
  assign earlyQuot  = divZero ? '1 : '0;
`else
  assign earlyOut  = 1'b0;
  assign earlyQuot = '0;
`endif

  // Control and datapath registers; handshake outputs are decoded into
  // registers alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            divisor_q <= i_divisor;
            count_q   <= '0;
            ready_q   <= 1'b0;
            if (earlyOut) begin
              quot_q  <= earlyQuot;
              rem_q   <= i_dividend;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              quot_q  <= i_dividend;
              rem_q   <= '0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          if (count_q == LAST) begin
            count_q <= '0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          count_q <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_quotient  = quot_q;
  assign o_remainder = rem_q;

endmodule
